// File: rtl/reg_file.sv
// Architectural register file with rename tags: two combinational operand reads, dispatch renames, RoB commits.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle matching commit onto the read ports.

module reg_file_rd_port #(
    parameter int          XLEN   = 32,
    parameter int          TAG_W  = 5,
    parameter logic [4:0]  NO_DEP = 5'd16
) (
    input  logic [4:0]       rs,
    input  logic [XLEN-1:0]  arch_val,
    input  logic [TAG_W-1:0] arch_tag,
    input  logic             byp_hit,
    input  logic [XLEN-1:0]  byp_val,
    output logic [XLEN-1:0]  val,
    output logic [TAG_W-1:0] rename
);
    always_comb begin
        val    = arch_val;
        rename = arch_tag;
        if (rs == 5'd0) begin
            val    = '0;
            rename = NO_DEP;
        end else if (byp_hit) begin
            val    = byp_val;
            rename = NO_DEP;
        end
    end
endmodule

module reg_file #(
    parameter int XLEN   = 32,
    parameter int NUM_RD = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [4:0]  rd_rs1,
    output logic [31:0] rd_val1,
    output logic [4:0]  rd_rename1,
    input  logic [4:0]  rd_rs2,
    output logic [31:0] rd_val2,
    output logic [4:0]  rd_rename2,
    input  logic        issue_en,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  issue_tag,
    input  logic        commit_en,
    input  logic [4:0]  commit_rd,
    input  logic [31:0] commit_val,
    input  logic [4:0]  commit_rename,
    input  logic        flush
);
    localparam logic [4:0] NO_DEP = 5'd16;

    logic [XLEN-1:0] regs [0:31];
    logic [4:0]      tags [0:31];

    // Flush and issue are applied after the commit tag clear so they win on the same register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
                tags[i] <= NO_DEP;
            end
        end else if (rdy_in) begin
            if (commit_en && commit_rd != 5'd0) begin
                regs[commit_rd] <= commit_val;
                if (tags[commit_rd] == commit_rename)
                    tags[commit_rd] <= NO_DEP;
            end
            if (flush) begin
                for (int i = 0; i < 32; i++)
                    tags[i] <= NO_DEP;
            end else if (issue_en && issue_rd != 5'd0) begin
                tags[issue_rd] <= issue_tag;
            end
        end
    end

    logic [NUM_RD-1:0][4:0]      rs;
    logic [NUM_RD-1:0][XLEN-1:0] arch_val, out_val;
    logic [NUM_RD-1:0][4:0]      arch_tag, out_tag;
    logic [NUM_RD-1:0]           byp_hit;

    assign rs = {rd_rs2, rd_rs1};

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            assign arch_val[p] = regs[rs[p]];
            assign arch_tag[p] = tags[rs[p]];
`ifdef REGFILE_BYPASS_EN
            // Only forward a commit that will actually land and clear the tag this edge.
            assign byp_hit[p] = rdy_in && commit_en && (commit_rd == rs[p]) && (rs[p] != 5'd0)
                                && (tags[rs[p]] == commit_rename);
`else
            assign byp_hit[p] = 1'b0;
`endif
            reg_file_rd_port #(.XLEN(XLEN), .TAG_W(5), .NO_DEP(NO_DEP)) u_rd (
                .rs       (rs[p]),
                .arch_val (arch_val[p]),
                .arch_tag (arch_tag[p]),
                .byp_hit  (byp_hit[p]),
                .byp_val  (commit_val),
                .val      (out_val[p]),
                .rename   (out_tag[p])
            );
        end
    endgenerate

    assign rd_val1    = out_val[0];
    assign rd_rename1 = out_tag[0];
    assign rd_val2    = out_val[1];
    assign rd_rename2 = out_tag[1];
endmodule

// File: tb/tb_reg_file.sv
// Directed vector bench for reg_file: table of per-cycle stimulus with pre-edge read expectations.
module tb_reg_file;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [4:0]  rd_rs1, rd_rs2;
    logic [31:0] rd_val1, rd_val2;
    logic [4:0]  rd_rename1, rd_rename2;
    logic        issue_en;
    logic [4:0]  issue_rd, issue_tag;
    logic        commit_en;
    logic [4:0]  commit_rd, commit_rename;
    logic [31:0] commit_val;
    logic        flush;

    int checks = 0;
    int errors = 0;

    reg_file dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rd_rs1(rd_rs1), .rd_val1(rd_val1), .rd_rename1(rd_rename1),
        .rd_rs2(rd_rs2), .rd_val2(rd_val2), .rd_rename2(rd_rename2),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_tag(issue_tag),
        .commit_en(commit_en), .commit_rd(commit_rd), .commit_val(commit_val),
        .commit_rename(commit_rename), .flush(flush)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rdy;
        logic        ie;
        logic [4:0]  ird;
        logic [4:0]  itag;
        logic        ce;
        logic [4:0]  crd;
        logic [31:0] cval;
        logic [4:0]  cren;
        logic        fl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] v1;
        logic [4:0]  t1;
        logic [31:0] v2;
        logic [4:0]  t2;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rdy_in = 1'b1; issue_en = 1'b0; issue_rd = '0; issue_tag = '0;
        commit_en = 1'b0; commit_rd = '0; commit_val = '0; commit_rename = '0;
        flush = 1'b0; rd_rs1 = '0; rd_rs2 = '0;
    endtask

    function automatic vec_t mk(input logic rdy, input logic ie, input logic [4:0] ird, input logic [4:0] itag,
                                input logic ce, input logic [4:0] crd, input logic [31:0] cval,
                                input logic [4:0] cren, input logic fl, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] v1, input logic [4:0] t1,
                                input logic [31:0] v2, input logic [4:0] t2);
        vec_t v;
        v.rdy = rdy; v.ie = ie; v.ird = ird; v.itag = itag; v.ce = ce; v.crd = crd; v.cval = cval;
        v.cren = cren; v.fl = fl; v.rs1 = rs1; v.rs2 = rs2; v.v1 = v1; v.t1 = t1; v.v2 = v2; v.t2 = t2;
        return v;
    endfunction

    initial begin
        //              rdy ie ird itag ce crd cval          cren fl rs1 rs2 v1            t1  v2       t2
        vecs[0]  = mk(1, 0, 0, 0,  0, 0, 32'h0,        0,  0, 0,  7,  32'h0,        16, 32'h0,  16);
        vecs[1]  = mk(1, 0, 0, 0,  1, 0, 32'hDEADBEEF, 16, 0, 31, 0,  32'h0,        16, 32'h0,  16);
        vecs[2]  = mk(1, 1, 5, 3,  0, 0, 32'h0,        0,  0, 0,  31, 32'h0,        16, 32'h0,  16);
        vecs[3]  = mk(1, 0, 0, 0,  0, 0, 32'h0,        0,  0, 5,  0,  32'h0,        3,  32'h0,  16);
        vecs[4]  = mk(1, 0, 0, 0,  1, 5, 32'h1234,     3,  0, 0,  31, 32'h0,        16, 32'h0,  16);
        vecs[5]  = mk(1, 0, 0, 0,  0, 0, 32'h0,        0,  0, 5,  7,  32'h1234,     16, 32'h0,  16);
        vecs[6]  = mk(1, 1, 5, 3,  0, 0, 32'h0,        0,  0, 0,  0,  32'h0,        16, 32'h0,  16);
        vecs[7]  = mk(1, 1, 5, 9,  0, 0, 32'h0,        0,  0, 5,  0,  32'h1234,     3,  32'h0,  16);
        vecs[8]  = mk(1, 0, 0, 0,  1, 5, 32'hAA,       3,  0, 5,  0,  32'h1234,     9,  32'h0,  16);
        vecs[9]  = mk(1, 0, 0, 0,  0, 0, 32'h0,        0,  0, 5,  0,  32'hAA,       9,  32'h0,  16);
        vecs[10] = mk(1, 1, 1, 1,  0, 0, 32'h0,        0,  0, 0,  0,  32'h0,        16, 32'h0,  16);
        vecs[11] = mk(1, 1, 2, 7,  0, 0, 32'h0,        0,  0, 1,  0,  32'h0,        1,  32'h0,  16);
        vecs[12] = mk(1, 1, 2, 4,  1, 1, 32'h55,       1,  1, 2,  5,  32'h0,        7,  32'hAA, 9);
        vecs[13] = mk(1, 0, 0, 0,  0, 0, 32'h0,        0,  0, 1,  2,  32'h55,       16, 32'h0,  16);
        vecs[14] = mk(1, 0, 0, 0,  0, 0, 32'h0,        0,  0, 5,  31, 32'hAA,       16, 32'h0,  16);
        vecs[15] = mk(1, 1, 3, 5,  0, 0, 32'h0,        0,  0, 0,  0,  32'h0,        16, 32'h0,  16);
        vecs[16] = mk(0, 1, 4, 6,  1, 3, 32'h99,       5,  0, 4,  0,  32'h0,        16, 32'h0,  16);
        vecs[17] = mk(1, 0, 0, 0,  0, 0, 32'h0,        0,  0, 3,  4,  32'h0,        5,  32'h0,  16);
        vecs[18] = mk(1, 0, 0, 0,  1, 3, 32'h99,       5,  0, 0,  4,  32'h0,        16, 32'h0,  16);
        vecs[19] = mk(1, 0, 0, 0,  0, 0, 32'h0,        0,  0, 3,  0,  32'h99,       16, 32'h0,  16);
        vecs[20] = mk(1, 1, 3, 8,  1, 3, 32'h11,       16, 0, 0,  7,  32'h0,        16, 32'h0,  16);
        vecs[21] = mk(1, 0, 0, 0,  0, 0, 32'h0,        0,  0, 3,  2,  32'h11,       8,  32'h0,  16);

        idle();
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk_in);
            rdy_in = vecs[i].rdy; issue_en = vecs[i].ie; issue_rd = vecs[i].ird; issue_tag = vecs[i].itag;
            commit_en = vecs[i].ce; commit_rd = vecs[i].crd; commit_val = vecs[i].cval;
            commit_rename = vecs[i].cren; flush = vecs[i].fl;
            rd_rs1 = vecs[i].rs1; rd_rs2 = vecs[i].rs2;
            #1;
            chk($sformatf("vec%0d val1", i), rd_val1, vecs[i].v1);
            chk($sformatf("vec%0d ren1", i), {27'd0, rd_rename1}, {27'd0, vecs[i].t1});
            chk($sformatf("vec%0d val2", i), rd_val2, vecs[i].v2);
            chk($sformatf("vec%0d ren2", i), {27'd0, rd_rename2}, {27'd0, vecs[i].t2});
        end

        // Same-cycle commit read of a pending register.
        @(negedge clk_in);
        idle(); issue_en = 1'b1; issue_rd = 5'd6; issue_tag = 5'd2;
        @(negedge clk_in);
        idle(); commit_en = 1'b1; commit_rd = 5'd6; commit_val = 32'h77; commit_rename = 5'd2;
        rd_rs1 = 5'd6;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp same val", rd_val1, 32'h77);
        chk("byp same ren", {27'd0, rd_rename1}, 32'd16);
`else
        chk("byp same val", rd_val1, 32'h0);
        chk("byp same ren", {27'd0, rd_rename1}, 32'd2);
`endif
        @(negedge clk_in);
        idle(); rd_rs1 = 5'd6;
        #1;
        chk("byp next val", rd_val1, 32'h77);
        chk("byp next ren", {27'd0, rd_rename1}, 32'd16);

        // Asynchronous reset mid-cycle wipes a pending rename and committed values at once.
        issue_en = 1'b1; issue_rd = 5'd9; issue_tag = 5'd2;
        @(negedge clk_in);
        idle(); rd_rs1 = 5'd9; rd_rs2 = 5'd3;
        #1;
        chk("pre-rst ren9", {27'd0, rd_rename1}, 32'd2);
        chk("pre-rst val3", rd_val2, 32'h11);
        #2 rst_in = 1'b0;
        #1;
        chk("rst ren9", {27'd0, rd_rename1}, 32'd16);
        chk("rst val3", rd_val2, 32'h0);
        chk("rst ren3", {27'd0, rd_rename2}, 32'd16);
        @(negedge clk_in);
        rst_in = 1'b1;
        rd_rs1 = 5'd6;
        #1;
        chk("post-rst val6", rd_val1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file with rename tags; the responder end of the reorder buffer's operand-lookup and commit interface. It answers two combinational operand reads per cycle with a value plus producing-RoB tag. It records the destination rename when an instruction is dispatched, and retires values when the RoB commits. It sits between the RoB/dispatch logic and the reservation stations and holds 32 × 32-bit registers with x0 hardwired to zero.

## Interface
- NO_DEP, 5'd16: tag meaning "no pending producer, value is architectural"; bit 4 set, RoB positions are 0–15.
- clk_in  input  1  system clock
- rst_in  input  1  reset; one clock; reset is asynchronous and active-low
- rdy_in  input  1  global enable; when low all state holds
- rd_rs1  input  5  operand-1 register index
- rd_val1  output  32  operand-1 value
- rd_rename1  output  5  operand-1 producer tag, or NO_DEP
- rd_rs2  input  5  operand-2 register index
- rd_val2  output  32  operand-2 value
- rd_rename2  output  5  operand-2 producer tag, or NO_DEP
- issue_en  input  1  dispatch allocates a rename this cycle
- issue_rd  input  5  destination register of dispatched instruction
- issue_tag  input  5  RoB position of dispatched instruction, {1'b0, pos}
- commit_en  input  1  RoB commits a register write this cycle
- commit_rd  input  5  committed destination
- commit_val  input  32  committed value
- commit_rename  input  5  RoB tag of committing entry, {1'b0, head}
- flush  input  1  mispredict recovery; discard all pending renames

## Operation
- State: regs[0:31] 32 bits each; tag[0:31] 5 bits each.
- Reads are combinational.
  - rd_valN = regs[rd_rsN] and rd_renameN = tag[rd_rsN].
  - Index 0 always returns value 0 and tag NO_DEP.
- Commit, on a clock edge with rdy_in=1 and commit_en=1:
  - regs[commit_rd] <= commit_val, unless commit_rd=0.
  - tag[commit_rd] <= NO_DEP only when tag[commit_rd]==commit_rename. A younger rename stays in place.
- Issue, on a clock edge with rdy_in=1, issue_en=1, flush=0 and issue_rd≠0: tag[issue_rd] <= issue_tag.
- Same register in one cycle: when commit and issue target the same register, the issue write wins for the tag. The value write still happens.
- Flush, on a clock edge with rdy_in=1 and flush=1:
  - Every tag <= NO_DEP.
  - Any same-cycle commit still writes its value.
  - A same-cycle issue is dropped.
- Writes to x0 are ignored by both commit and issue.
- Reset (rst_in low, asynchronous): all regs <= 0 and all tags <= NO_DEP. Outputs therefore read 0/NO_DEP for every index until the first commit or issue.
- Reset asserted mid-operation discards every pending rename immediately. There are no partial updates.

## Timing
- Read latency is 0 cycles (combinational).
- Commit and issue updates are visible to reads from the cycle after the edge.
- A dispatching instruction reads its operands in the same cycle it issues. Because reads see pre-edge state, an instruction never sees its own rename (e.g. addi x5,x5,1 reads the old x5 tag).
- Back-to-back issues to the same rd: the later tag overwrites the earlier one. The commit of the earlier tag then leaves the tag unchanged.
- rdy_in=0 freezes all state. Reads remain live.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle commit forwarding on the read ports.
  - Applies when commit_en=1, commit_rd==rd_rsN≠0 and tag[rd_rsN]==commit_rename.
  - Then rd_valN=commit_val and rd_renameN=NO_DEP in that same cycle.
- REGFILE_BYPASS_EN undefined: reads return pre-commit state only. Consumers must snoop the commit bus to resolve the returned tag.

## Test plan
- Reset:
  - Stimulus: pulse rst_in low, then read x0, x7 and x31.
  - Required: value 0 and tag 16 on all three; a commit to x0 of 0xDEADBEEF still reads 0.
- Rename then commit:
  - Stimulus: issue rd=x5 with tag 3; next cycle read x5; then commit x5=0x1234 with rename 3.
  - Required: the read returns tag 3; after the commit, x5 reads 0x1234 with tag 16.
- Stale commit:
  - Stimulus: issue x5 tag 3, then issue x5 tag 9, then commit x5=0xAA with rename 3.
  - Required: x5 reads 0xAA with tag 9.
- Simultaneous commit, issue and flush:
  - Stimulus: tags of x1 and x2 pending; in one cycle commit x1=0x55 with its tag, issue x2 tag 4, and assert flush.
  - Required: x1=0x55 with tag 16; x2 tag 16; issue dropped.
- Bypass:
  - Stimulus: x6 tag 2 pending; in one cycle commit x6=0x77 with rename 2 and read x6.
  - Required with REGFILE_BYPASS_EN: 0x77 and tag 16 that same cycle.
  - Required without it: old value and tag 2 that cycle, new value and tag 16 next cycle.
- rdy_in hold:
  - Stimulus: drive rdy_in=0 with commit_en and issue_en both asserted.
  - Required: all registers and tags unchanged.
